// File: rtl/sine_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sine_seq_pkg
// Purpose  : Shared definitions for the sine-generation sequencer: register
//            map, sequencer state encoding and the pi/2 angle constant.
// Revision : 1.0  initial release
// ============================================================================
package sine_seq_pkg;

  // Register map of the software write port
  localparam logic [1:0] ADDR_FREQ  = 2'd0;
  localparam logic [1:0] ADDR_DIV   = 2'd1;
  localparam logic [1:0] ADDR_CTRL  = 2'd2;
  localparam logic [1:0] ADDR_FSTOP = 2'd3;

  // Sequencer states
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    SWEEP = 2'd2,
    DRAIN = 2'd3
  } state_t;

  // pi/2 in Q2.14: the top of the CORDIC's legal angle range
  localparam int PI_HALF_Q14 = 25736;

endpackage
`default_nettype wire

// File: rtl/sine_seq_phase_fold.sv
`default_nettype none
// ============================================================================
// Module   : phase_fold
// Purpose  : Folds a 16-bit full-circle phase into the first quadrant and
//            scales it to a Q2.14 angle (0..pi/2). The quadrant sign is kept
//            as a negate flag. Angle and flag are registered on a tick; the
//            tick itself is registered every cycle so it stays aligned.
// Ports    : clk, rst_n     clock, async active-low reset
//            tick_i         phase sample strobe
//            ph_i[15:0]     phase, full scale = 2*pi
//            angle_o        Q2.14 angle, 0..25736, zero-extended
//            neg_o          sample must be negated (lower half of circle)
//            tick_o         tick_i delayed one clock, aligned with angle_o
// Revision : 1.0  initial release
// ============================================================================
module phase_fold #(
  parameter int BITS = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          tick_i,
  input  logic [15:0]   ph_i,
  output logic [BITS:0] angle_o,
  output logic          neg_o,
  output logic          tick_o
);
  import sine_seq_pkg::*;

  localparam int AW = BITS + 1;

  logic [1:0]  w_q;
  logic [13:0] w_r;
  logic [14:0] w_rf;
  logic [28:0] w_prod;
  logic [14:0] w_angle;

  assign w_q = ph_i[15:14];
  assign w_r = ph_i[13:0];

  // Odd quadrants run backwards: r' = 16384 - r (r=0 gives the full 16384)
  assign w_rf = w_q[0] ? (15'd16384 - {1'b0, w_r}) : {1'b0, w_r};

  // 16384 * 25736 < 2^29, so 29 bits hold the full product
  assign w_prod  = 29'(w_rf) * 29'(PI_HALF_Q14);
  assign w_angle = 15'(w_prod >> 14);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      angle_o <= '0;
      neg_o   <= 1'b0;
      tick_o  <= 1'b0;
    end else begin
      tick_o <= tick_i;
      if (tick_i) begin
        angle_o <= AW'(w_angle);
        neg_o   <= w_q[1];
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/sine_seq.sv
`default_nettype none
// ============================================================================
// Module   : sine_seq
// Purpose  : Sample-rate sequencer for the sine datapath. Owns the phase
//            accumulator and sample divider, feeds folded angles to an
//            external CORDIC, tracks the quadrant sign through the CORDIC
//            latency and emits sign-restored samples to the DAC.
// Config   : SINE_SEQ_SWEEP_EN enables the linear frequency sweep (SWEEP
//            state, FSTOP register, CTRL.sweep and CTRL.FSTEP).
// Ports    : clk, rst_n              clock, async active-low reset
//            wr_en/wr_addr/wr_data   register write port
//                                    (0=FREQ 1=DIV 2=CTRL 3=FSTOP)
//            angle_o                 Q2.14 angle to the CORDIC
//            sinus_i                 CORDIC sine result, signed
//            sample_o, sample_vld_o  signed sample and its update pulse
//            busy_o                  sequencer not in IDLE
// Revision : 1.0  initial release
// ============================================================================
module sine_seq #(
  parameter int BITS       = 16,
  parameter int CORDIC_LAT = 14
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [1:0]             wr_addr,
  input  logic [15:0]            wr_data,
  output logic [BITS:0]          angle_o,
  input  logic signed [BITS-1:0] sinus_i,
  output logic signed [BITS-1:0] sample_o,
  output logic                   sample_vld_o,
  output logic                   busy_o
);
  import sine_seq_pkg::*;

  localparam int DCW = $clog2(CORDIC_LAT + 1);
  localparam logic signed [BITS-1:0] c_smin = {1'b1, {(BITS-1){1'b0}}};
  localparam logic signed [BITS-1:0] c_smax = {1'b0, {(BITS-1){1'b1}}};

  state_t                r_state;
  logic [15:0]           r_freq;
  logic [15:0]           r_div;
  logic                  r_run;
  logic [15:0]           r_ph;
  logic [15:0]           r_div_cnt;
  logic [DCW-1:0]        r_drain_cnt;
  logic [CORDIC_LAT-1:0] r_tick_sr;
  logic [CORDIC_LAT-1:0] r_neg_sr;

  logic                  w_wr_ctrl;
  logic                  w_run_nxt;
  logic                  w_sweep_nxt;
  logic                  w_tick;
  logic                  w_sweep_upd;
  logic                  w_sweep_done;
  logic                  w_fold_neg;
  logic                  w_fold_tick;
  logic signed [BITS-1:0] w_sin_neg;

  // The FSM reacts to a CTRL write on the same edge that stores it, so the
  // sequencer enters RUN together with the register update.
  assign w_wr_ctrl = wr_en && (wr_addr == ADDR_CTRL);
  assign w_run_nxt = w_wr_ctrl ? wr_data[0] : r_run;

  // A tick is suppressed in the cycle that stops the run, so every tick
  // issued before DRAIN is covered by the DRAIN wait.
  assign w_tick = ((r_state == RUN) || (r_state == SWEEP)) &&
                  (r_div_cnt == 16'd0) && w_run_nxt;

`ifdef SINE_SEQ_SWEEP_EN
  logic        r_sweep;
  logic [13:0] r_fstep;
  logic [15:0] r_fstop;
  logic [16:0] w_freq_sum;

  assign w_sweep_nxt  = w_wr_ctrl ? wr_data[1] : r_sweep;
  assign w_sweep_upd  = (r_state == SWEEP) && w_tick;
  assign w_freq_sum   = {1'b0, r_freq} + {3'b000, r_fstep};
  assign w_sweep_done = (w_freq_sum >= {1'b0, r_fstop});

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sweep <= 1'b0;
      r_fstep <= '0;
      r_fstop <= '0;
    end else if (wr_en) begin
      if (wr_addr == ADDR_CTRL) begin
        r_sweep <= wr_data[1];
        r_fstep <= wr_data[15:2];
      end
      if (wr_addr == ADDR_FSTOP) r_fstop <= wr_data;
    end
  end
`else
  assign w_sweep_nxt  = 1'b0;
  assign w_sweep_upd  = 1'b0;
  assign w_sweep_done = 1'b0;
`endif

  // FREQ: a software write overrides a sweep step in the same cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_freq <= '0;
    end else if (wr_en && (wr_addr == ADDR_FREQ)) begin
      r_freq <= wr_data;
`ifdef SINE_SEQ_SWEEP_EN
    end else if (w_sweep_upd) begin
      r_freq <= w_sweep_done ? r_fstop : w_freq_sum[15:0];
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_div <= '0;
      r_run <= 1'b0;
    end else if (wr_en) begin
      if (wr_addr == ADDR_DIV)  r_div <= wr_data;
      if (wr_addr == ADDR_CTRL) r_run <= wr_data[0];
    end
  end

  // Sequencer, divider and phase accumulator
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_div_cnt   <= '0;
      r_drain_cnt <= '0;
      r_ph        <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_div_cnt <= '0;
          if (w_run_nxt) r_state <= w_sweep_nxt ? SWEEP : RUN;
        end
        RUN, SWEEP: begin
          if (w_tick) r_ph <= r_ph + r_freq;
          // >= keeps the count bounded if DIV is lowered mid-count
          r_div_cnt <= (r_div_cnt >= r_div) ? 16'd0 : r_div_cnt + 16'd1;
          if (!w_run_nxt) begin
            r_state     <= DRAIN;
            r_drain_cnt <= '0;
          end else if (w_sweep_upd && w_sweep_done) begin
            r_state <= RUN;
          end
        end
        DRAIN: begin
          r_ph <= '0;
          if (r_drain_cnt == DCW'(CORDIC_LAT - 1)) r_state <= IDLE;
          else r_drain_cnt <= r_drain_cnt + DCW'(1);
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  phase_fold #(.BITS(BITS)) u_phase_fold (
    .clk     (clk),
    .rst_n   (rst_n),
    .tick_i  (w_tick),
    .ph_i    (r_ph),
    .angle_o (angle_o),
    .neg_o   (w_fold_neg),
    .tick_o  (w_fold_tick)
  );

  // Tick/negate delay line matching the CORDIC pipeline. Clearing it on
  // reset discards whatever stale results the CORDIC still holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick_sr <= '0;
      r_neg_sr  <= '0;
    end else begin
      r_tick_sr <= {r_tick_sr[CORDIC_LAT-2:0], w_fold_tick};
      r_neg_sr  <= {r_neg_sr[CORDIC_LAT-2:0], w_fold_neg};
    end
  end

  // The most negative code has no positive twin; clamp its negation
  assign w_sin_neg = (sinus_i == c_smin) ? c_smax : -sinus_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sample_o     <= '0;
      sample_vld_o <= 1'b0;
    end else if (r_tick_sr[CORDIC_LAT-1]) begin
      sample_o     <= r_neg_sr[CORDIC_LAT-1] ? w_sin_neg : sinus_i;
      sample_vld_o <= 1'b1;
    end else begin
      sample_vld_o <= 1'b0;
      if (r_state == IDLE) sample_o <= '0;
    end
  end

  assign busy_o = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sine_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_sine_seq
// Purpose  : Self-checking bench for sine_seq. A stand-in CORDIC returns the
//            delayed angle itself as the sine value (or the most negative
//            code on demand), so expected samples are the hand-computed
//            folded angles with the quadrant sign applied.
// Revision : 1.0  initial release
// ============================================================================
module tb_sine_seq;
  import sine_seq_pkg::*;

  localparam int BITS = 16;
  localparam int LAT  = 14;

  logic                   clk     = 1'b0;
  logic                   rst_n   = 1'b0;
  logic                   wr_en   = 1'b0;
  logic [1:0]             wr_addr = 2'd0;
  logic [15:0]            wr_data = 16'd0;
  logic [BITS:0]          angle_o;
  logic signed [BITS-1:0] sinus_i;
  logic signed [BITS-1:0] sample_o;
  logic                   sample_vld_o;
  logic                   busy_o;

  sine_seq #(.BITS(BITS), .CORDIC_LAT(LAT)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .angle_o      (angle_o),
    .sinus_i      (sinus_i),
    .sample_o     (sample_o),
    .sample_vld_o (sample_vld_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // CORDIC stand-in: LAT-clock pipeline, sine := angle
  logic [BITS:0] cpipe [LAT];
  logic          force_min = 1'b0;
  always @(posedge clk) begin
    cpipe[0] <= angle_o;
    for (int i = 1; i < LAT; i++) cpipe[i] <= cpipe[i-1];
  end
  assign sinus_i = force_min ? 16'h8000 : cpipe[LAT-1][BITS-1:0];

  int n_total = 0;
  int n_bad   = 0;
  int sb_q[$];
  int vld_times[$];
  int last_wr_cyc = 0;

  task automatic check(input string name, input int act, input int exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: pop one expected sample per DUT sample pulse
  always @(negedge clk) begin
    if (rst_n && sample_vld_o) begin
      vld_times.push_back(cyc);
      if (sb_q.size() > 0) check("sample", int'(sample_o), sb_q.pop_front());
    end
  end

  // Called at a negedge; the write is taken on the following posedge
  task automatic reg_wr(input logic [1:0] a, input logic [15:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(negedge clk);
    wr_en       = 1'b0;
    last_wr_cyc = cyc;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    sb_q.delete();
    vld_times.delete();
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_sb(input int budget);
    int n = 0;
    while (sb_q.size() > 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    if (sb_q.size() > 0) begin
      n_total++;
      n_bad++;
      $display("FAIL sb_timeout: %0d samples pending, expected 0", sb_q.size());
      sb_q.delete();
    end
  endtask

  task automatic expect_angles(input int a0, input int a1, input int a2, input int a3);
    int exp[4];
    exp = '{a0, a1, a2, a3};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("angle", int'(angle_o), exp[i]);
    end
  endtask

  initial begin
    int n;
    int t0;
    @(negedge clk);
    do_reset();

    // Reset values
    check("rst_angle", int'(angle_o), 0);
    check("rst_sample", int'(sample_o), 0);
    check("rst_vld", int'(sample_vld_o), 0);
    check("rst_busy", int'(busy_o), 0);

    // Quadrant fold: FREQ=0x4000, DIV=0
    sb_q = '{0, 25736, 0, -25736};
    reg_wr(ADDR_FREQ, 16'h4000);
    reg_wr(ADDR_CTRL, 16'h0001);
    check("run_busy", int'(busy_o), 1);
    expect_angles(0, 25736, 0, 25736);
    wait_sb(40);

    // Negation of the most negative CORDIC code saturates
    do_reset();
    force_min = 1'b1;
    sb_q = '{-32768, -32768, 32767, 32767};
    reg_wr(ADDR_FREQ, 16'h4000);
    reg_wr(ADDR_CTRL, 16'h0001);
    wait_sb(40);
    force_min = 1'b0;

    // Divider: DIV=3 -> one sample per 4 clocks, first at LAT+2
    do_reset();
    sb_q = '{0, 6434, 12868, 19302};
    reg_wr(ADDR_FREQ, 16'h1000);
    reg_wr(ADDR_DIV, 16'd3);
    reg_wr(ADDR_CTRL, 16'h0001);
    t0 = last_wr_cyc;
    n = 0;
    while (vld_times.size() < 4 && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (vld_times.size() < 4) begin
      n_total++;
      n_bad++;
      $display("FAIL div_timeout: %0d pulses, expected 4", vld_times.size());
    end else begin
      check("first_latency", vld_times[0] - t0, LAT + 2);
      for (int i = 1; i < 4; i++)
        check("div_period", vld_times[i] - vld_times[i-1], 4);
    end
    wait_sb(20);

    // Phase wrap: FREQ=0xC000 -> ph C000, 8000, 4000, 0000
    do_reset();
    sb_q = '{0, -25736, 0, 25736};
    reg_wr(ADDR_FREQ, 16'hC000);
    reg_wr(ADDR_CTRL, 16'h0001);
    expect_angles(0, 25736, 0, 25736);
    wait_sb(40);

    // FREQ rewritten to 0 mid-run: phase freezes at 0x2000
    do_reset();
    sb_q = '{0, 12868, 12868, 12868};
    reg_wr(ADDR_FREQ, 16'h2000);
    reg_wr(ADDR_CTRL, 16'h0001);
    reg_wr(ADDR_FREQ, 16'h0000);
    wait_sb(40);

    // Sweep FREQ=100, FSTEP=50, FSTOP=260
    do_reset();
`ifdef SINE_SEQ_SWEEP_EN
    sb_q = '{0, 157, 392, 706, 1099, 1507};
`else
    sb_q = '{0, 157, 314, 471, 628, 785};
`endif
    reg_wr(ADDR_FSTOP, 16'd260);
    reg_wr(ADDR_FREQ, 16'd100);
    reg_wr(ADDR_CTRL, 16'd203);
    wait_sb(50);

    // Stop/drain with DIV=0: LAT samples still in flight
    do_reset();
    reg_wr(ADDR_FREQ, 16'h1000);
    reg_wr(ADDR_CTRL, 16'h0001);
    repeat (30) @(negedge clk);
    reg_wr(ADDR_CTRL, 16'h0000);
    check("drain_busy", int'(busy_o), 1);
    n = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (sample_vld_o) n++;
    end
    check("drain_count", n, LAT);
    check("idle_busy", int'(busy_o), 0);
    check("idle_sample", int'(sample_o), 0);

    // Asynchronous reset mid-run
    do_reset();
    reg_wr(ADDR_FREQ, 16'h1000);
    reg_wr(ADDR_CTRL, 16'h0001);
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_angle", int'(angle_o), 0);
    check("mid_rst_sample", int'(sample_o), 0);
    check("mid_rst_vld", int'(sample_vld_o), 0);
    check("mid_rst_busy", int'(busy_o), 0);
    rst_n = 1'b1;
    n = 0;
    for (int i = 0; i < LAT + 4; i++) begin
      @(negedge clk);
      if (sample_vld_o) n++;
    end
    check("post_rst_vld", n, 0);
    check("post_rst_busy", int'(busy_o), 0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
